// File: rtl/keypad_scanner.sv
// 4x4 key matrix scanner: synchronises the rows, scans one column per SCAN_DIV cycles,
// and debounces whole frames into one key code. Optional build macro: KEYPAD_GHOST_REJECT_EN.
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       mclk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [5:0] key_code,
  output logic       key_strobe
);

  localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  CNT_MAX    = 4'(DEBOUNCE_CNT);

  // The whole column rotation is frame accumulation; the state is the column being scanned.
  typedef enum logic [1:0] {
    ACC_COL0 = 2'd0,
    ACC_COL1 = 2'd1,
    ACC_COL2 = 2'd2,
    ACC_COL3 = 2'd3
  } scan_state_e;

  scan_state_e state_q, state_d;
  logic [3:0]  row_s1_q, row_s1_d;
  logic [3:0]  row_s2_q, row_s2_d;
  logic [15:0] dwell_q, dwell_d;
  logic [3:0]  col_q, col_d;
  logic        found_q, found_d;
  logic [5:0]  code_q, code_d;
  logic [5:0]  cand_q, cand_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  key_q, key_d;
  logic        strobe_q, strobe_d;
`ifdef KEYPAD_GHOST_REJECT_EN
  logic        multi_q, multi_d;
  logic        acc_multi;
`endif

  logic [3:0] row_act;
  logic       acc_found;
  logic [5:0] acc_code;
  logic [5:0] raw;
  logic [3:0] cnt_nx;

  always_comb begin
    row_s1_d  = row_in;
    row_s2_d  = row_s1_q;
    row_act   = ~row_s2_q;
    state_d   = state_q;
    dwell_d   = dwell_q + 16'd1;
    col_d     = col_q;
    found_d   = found_q;
    code_d    = code_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    strobe_d  = 1'b0;
    acc_found = found_q;
    acc_code  = code_q;
    raw       = 6'd0;
    cnt_nx    = cnt_q;
`ifdef KEYPAD_GHOST_REJECT_EN
    multi_d   = multi_q;
    acc_multi = multi_q;
`endif

    if (dwell_q == DWELL_LAST) begin
      dwell_d = 16'd0;
      state_d = scan_state_e'(state_q + 2'd1);
      col_d   = {col_q[2:0], col_q[3]};

      // Ascending row order makes the lowest code in the frame win.
      for (int r = 0; r < 4; r++) begin
        if (row_act[r]) begin
          if (!acc_found) begin
            acc_code  = {2'b00, state_q, 2'(r)} + 6'd1;
            acc_found = 1'b1;
          end
`ifdef KEYPAD_GHOST_REJECT_EN
          else begin
            acc_multi = 1'b1;
          end
`endif
        end
      end

      if (state_q == ACC_COL3) begin
        raw = acc_found ? acc_code : 6'd0;
`ifdef KEYPAD_GHOST_REJECT_EN
        if (acc_multi) raw = 6'd0;
        multi_d = 1'b0;
`endif
        found_d = 1'b0;
        code_d  = 6'd0;

        if (raw == cand_q) begin
          cnt_nx = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 4'd1;
        end else begin
          cand_d = raw;
          cnt_nx = 4'd1;
        end
        cnt_d = cnt_nx;

        if (cnt_nx == CNT_MAX && raw != key_q) begin
          key_d    = raw;
          strobe_d = (key_q == 6'd0) && (raw != 6'd0);
        end
      end else begin
        found_d = acc_found;
        code_d  = acc_code;
`ifdef KEYPAD_GHOST_REJECT_EN
        multi_d = acc_multi;
`endif
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      state_q  <= ACC_COL0;
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
      dwell_q  <= 16'd0;
      col_q    <= 4'b1110;
      found_q  <= 1'b0;
      code_q   <= 6'd0;
      cand_q   <= 6'd0;
      cnt_q    <= 4'd0;
      key_q    <= 6'd0;
      strobe_q <= 1'b0;
`ifdef KEYPAD_GHOST_REJECT_EN
      multi_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      row_s1_q <= row_s1_d;
      row_s2_q <= row_s2_d;
      dwell_q  <= dwell_d;
      col_q    <= col_d;
      found_q  <= found_d;
      code_q   <= code_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      key_q    <= key_d;
      strobe_q <= strobe_d;
`ifdef KEYPAD_GHOST_REJECT_EN
      multi_q  <= multi_d;
`endif
    end
  end

  assign col_out    = col_q;
  assign key_code   = key_q;
  assign key_strobe = strobe_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a key-matrix model drives row_in from col_out, and a frame-level
// debounce model predicts key_code, key_strobe and the column rotation every cycle.
module tb_keypad_scanner;
  localparam int S  = 4;
  localparam int DB = 2;

  logic       mclk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [5:0] key_code;
  logic       key_strobe;

  logic [15:0] pressed = 16'h0000;
  int n_cmp = 0;
  int n_bad = 0;
  int exp_key = 0;
  int hist[$];

  always #5 mclk = ~mclk;

  keypad_scanner #(.SCAN_DIV(S), .DEBOUNCE_CNT(DB)) dut (
    .mclk(mclk), .rst_n(rst_n), .row_in(row_in),
    .col_out(col_out), .key_code(key_code), .key_strobe(key_strobe)
  );

  // Pressed key at (col c, row r) is bit c*4+r; it pulls row r low while column c is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (col_out[c] === 1'b0 && pressed[c*4+r]) row_in[r] = 1'b0;
  end

  function automatic int frame_raw(input logic [15:0] keys);
    int n, low;
    n = 0; low = 0;
    for (int k = 0; k < 16; k++)
      if (keys[k]) begin
        if (n == 0) low = k + 1;
        n++;
      end
`ifdef KEYPAD_GHOST_REJECT_EN
    if (n > 1) low = 0;
`endif
    return low;
  endfunction

  // key_code takes raw once the last DB frame results agree and differ from it.
  task automatic model_frame_end(input int raw, output int exp_strobe);
    bit stable;
    hist.push_back(raw);
    if (hist.size() > DB) void'(hist.pop_front());
    exp_strobe = 0;
    stable = (hist.size() == DB);
    foreach (hist[k]) if (hist[k] != raw) stable = 0;
    if (stable && raw != exp_key) begin
      exp_strobe = (exp_key == 0 && raw != 0);
      exp_key = raw;
    end
  endtask

  task automatic model_reset();
    hist.delete();
    exp_key = 0;
  endtask

  task automatic run_frame(input logic [15:0] keys);
    int es;
    logic [3:0] one, exp_col;
    pressed = keys;
    for (int i = 0; i < 4*S; i++) begin
      @(posedge mclk); #1;
      es = 0;
      if (i == 4*S-1) model_frame_end(frame_raw(keys), es);
      one = 4'b0001 << (((i + 1) / S) % 4);
      exp_col = ~one;
      n_cmp++;
      if (col_out !== exp_col) begin
        n_bad++; $display("FAIL col_out: got %b expected %b (cycle %0d)", col_out, exp_col, i);
      end
      n_cmp++;
      if (key_code !== 6'(exp_key)) begin
        n_bad++; $display("FAIL key_code: got %0d expected %0d (cycle %0d)", key_code, exp_key, i);
      end
      n_cmp++;
      if (key_strobe !== es[0]) begin
        n_bad++; $display("FAIL key_strobe: got %b expected %0d (cycle %0d)", key_strobe, es, i);
      end
    end
  endtask

  task automatic expect_key(input string name, input int want);
    n_cmp++;
    if (key_code !== 6'(want)) begin
      n_bad++; $display("FAIL %s: key_code got %0d expected %0d", name, key_code, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pressed = 16'h0000;
    repeat (3) @(posedge mclk);
    #1;
    n_cmp++;
    if (col_out !== 4'b1110) begin n_bad++; $display("FAIL reset_col: got %b expected 1110", col_out); end
    expect_key("reset_key", 0);
    n_cmp++;
    if (key_strobe !== 1'b0) begin n_bad++; $display("FAIL reset_strobe: got %b expected 0", key_strobe); end
    rst_n = 1'b1;
    model_reset();
    run_frame(16'h0000);
    run_frame(16'h0000);
  endtask

  task automatic test_single_press();
    run_frame(16'h0001 << 9);
    run_frame(16'h0001 << 9);
    expect_key("single_press", 10);
    run_frame(16'h0000);
    expect_key("single_release_early", 10);
    run_frame(16'h0000);
    expect_key("single_release", 0);
  endtask

  task automatic test_bounce();
    run_frame(16'h8000);
    run_frame(16'h0000);
    run_frame(16'h8000);
    expect_key("bounce_hold", 0);
    run_frame(16'h8000);
    expect_key("bounce_settled", 16);
  endtask

  task automatic test_two_keys();
    run_frame(16'h0000);
    run_frame(16'h0000);
    run_frame((16'h0001 << 4) | (16'h0001 << 14));
    run_frame((16'h0001 << 4) | (16'h0001 << 14));
`ifdef KEYPAD_GHOST_REJECT_EN
    expect_key("two_keys_ghost", 0);
`else
    expect_key("two_keys_lowest", 5);
`endif
  endtask

  task automatic test_rollover();
    run_frame(16'h0000);
    run_frame(16'h0000);
    run_frame(16'h0001 << 2);
    run_frame(16'h0001 << 2);
    expect_key("rollover_first", 3);
    run_frame(16'h0001 << 8);
    expect_key("rollover_hold", 3);
    run_frame(16'h0001 << 8);
    expect_key("rollover_second", 9);
  endtask

  task automatic test_reset_mid();
    run_frame(16'h0000);
    run_frame(16'h0000);
    run_frame(16'h0001);
    run_frame(16'h0001);
    expect_key("mid_before", 1);
    repeat (5) @(posedge mclk);
    #1;
    rst_n = 1'b0;
    @(posedge mclk); #1;
    expect_key("mid_reset_key", 0);
    n_cmp++;
    if (col_out !== 4'b1110) begin n_bad++; $display("FAIL mid_reset_col: got %b expected 1110", col_out); end
    n_cmp++;
    if (key_strobe !== 1'b0) begin n_bad++; $display("FAIL mid_reset_strobe: got %b expected 0", key_strobe); end
    repeat (2) @(posedge mclk);
    #1;
    rst_n = 1'b1;
    model_reset();
    run_frame(16'h0001);
    expect_key("mid_reacquire_early", 0);
    run_frame(16'h0001);
    expect_key("mid_reacquire", 1);
  endtask

  task automatic test_random();
    logic [15:0] keys;
    keys = 16'h0000;
    for (int f = 0; f < 60; f++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: ;
        5:             keys = 16'h0000;
        6, 7, 8:       keys = 16'h0001 << $urandom_range(0, 15);
        default:       keys = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      endcase
      run_frame(keys);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_two_keys();
    test_rollover();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

- Scans the 4x4 front-panel key matrix, resynchronises and debounces it, and presents one stable key code.
- Its `key_code` output drives the time/timer-setting controller directly.
- Encoding:
  - 0 means no key.
  - Keys are numbered 1..16, column-major: code = column*4 + row + 1.
- `key_code` must return to 0 between presses, because the downstream controller acts only on a 0 -> nonzero transition.

## Interface

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven; legal range 4..65535.
- DEBOUNCE_CNT, 4: consecutive identical frames required before `key_code` changes; legal range 1..15.

Ports:
- mclk  input  1  system clock, all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- row_in  input  4  matrix rows:
  - active-low, externally pulled up, asynchronous to `mclk`;
  - bit r is row r.
- col_out  output  4  matrix column drive:
  - active-low one-hot;
  - bit c low means column c is being scanned.
- key_code  output  6  debounced code, 0 = none, 1..16 = key.
- key_strobe  output  1  one-cycle pulse when `key_code` goes from 0 to nonzero.

## Operation

Input synchronisation:
- `row_in` passes through a 2-flop synchroniser before any use.
- The synchronised vector is inverted to `row_act` (1 = pressed).

Column scan:
- A dwell counter counts 0..SCAN_DIV-1.
- At terminal count:
  - the dwell counter wraps to 0;
  - the column index advances 0->1->2->3->0;
  - `col_out` rotates to the next column.
- Rows are sampled only at dwell count SCAN_DIV-1. This allows 2 cycles of synchroniser latency plus matrix settling.

Frame accumulation (one frame = 4 columns = 4*SCAN_DIV cycles):
- Scan state is FRAME_ACC (columns 0..3); there is no separate idle state.
- At each sample, for every row r with `row_act[r]` = 1, in ascending order:
  - if no key has been found yet this frame: record code = col*4 + r + 1 and set `found`;
  - otherwise: set `multi`.
- Net effect: the lowest code wins.

Frame end (the sample edge of column 3):
- `raw` = recorded code, or 0 if none found.
- The accumulators (`found`, `multi`, code) clear at this same edge for the next frame.

Debounce, evaluated at frame end only:
- If `raw` == `cand`: `cnt` <= min(`cnt`+1, DEBOUNCE_CNT).
- Otherwise: `cand` <= `raw` and `cnt` <= 1.
- If the next value of `cnt` == DEBOUNCE_CNT and `raw` != `key_code`: `key_code` <= `raw`.
- A direct nonzero -> different nonzero change (roll-over) is allowed and does not strobe.
- `key_strobe` <= 1 only when `key_code` is written from 0 to nonzero. Otherwise it is 0 every cycle.

Reset values (`rst_n` = 0 at a rising edge):
- `col_out` = 4'b1110 (column 0).
- Dwell counter 0.
- Synchroniser flops all 1s.
- Accumulators cleared.
- `cand` = 0, `cnt` = 0.
- `key_code` = 0, `key_strobe` = 0.
- Reset mid-frame discards the partial frame.
- Reset while a key is held: `key_code` goes to 0 at once and is re-acquired after DEBOUNCE_CNT full frames.

## Timing

- Frame period: 4*SCAN_DIV cycles.
- The first frame after reset release ends at cycle 4*SCAN_DIV-1, counting the first non-reset edge as cycle 0.
- Press latency:
  - a key stably pressed from before a frame's sample of its column appears after exactly DEBOUNCE_CNT frame-ends;
  - `key_code` and `key_strobe` are updated at that frame-end edge.
- Release latency: the same rule; `key_code` returns to 0 after DEBOUNCE_CNT all-clear frames.
- Bounce:
  - any frame whose `raw` differs from `cand` restarts `cnt` at 1;
  - `key_code` holds its previous value meanwhile.
- DEBOUNCE_CNT = 1: `key_code` follows `raw` at every frame end.
- `key_strobe` is high for exactly one `mclk` cycle, coincident with the first cycle `key_code` shows the new value.
- `col_out`, `key_code` and `key_strobe` are registered outputs; nothing combinational reaches a port.

## Configuration

- Macro: KEYPAD_GHOST_REJECT_EN.
- Defined:
  - any frame with `multi` = 1 yields `raw` = 0;
  - multi-key and ghosted presses are treated as no key, and an existing `key_code` is released through normal debounce.
- Undefined:
  - `multi` is ignored and the lowest code wins;
  - the `multi` flag logic is not compiled.

## Test plan

Run with SCAN_DIV=4, DEBOUNCE_CNT=2 unless noted.

- Reset: `rst_n` low 3 cycles with `row_in`=4'b1111 -> `col_out`=4'b1110, `key_code`=0, `key_strobe`=0; `col_out` advances every 4 cycles after release.
- Single press: pull row 1 low whenever column 2 is driven -> after the 2nd frame-end `key_code`=10 with a 1-cycle `key_strobe`; release -> `key_code`=0 two frame-ends later, no strobe.
- Bounce: press key 16 (col 3, row 3) for 1 frame, open 1 frame, then hold -> `key_code` stays 0 until 2 consecutive pressed frames, then 16.
- Two keys, codes 5 and 15, held together:
  - without the macro -> `key_code`=5;
  - with KEYPAD_GHOST_REJECT_EN -> `key_code` stays 0.
- Roll-over: hold key 3, then switch to key 9 with no gap -> `key_code` goes 3->9 directly after 2 frames, `key_strobe` stays 0.
- Reset mid-frame with key 1 held -> `key_code`=0 immediately, back to 1 after 2 full frames following release of `rst_n`.
